// File: rtl/hazard_controller.sv
`timescale 1ns/1ps
// Pipeline hazard controller for a 5-stage RISC-V style core.
// Resolves data-memory misses (stall the whole front of the pipe, bubble W),
// load-use hazards (stall F/D, bubble E), taken branches (flush D/E) and
// selects E-stage operand forwarding. Also keeps saturating stall/flush counters.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   Rs1D_i/Rs2D_i, Rs1E_i/Rs2E_i        D- and E-stage source registers
//   RdE_i/RdM_i/RdW_i                   E/M/W destination registers
//   ResultSrcE_i, RegWriteM_i/W_i       E result select (01 = load), M/W write enables
//   PCSrcE_i                            taken branch/jump in E
//   MemReqM_i, MemReady_i               M-stage memory request, data memory done
//   CntClr_i                            synchronous counter clear
//   Stall*_o, Flush*_o                  per-stage hold / clear controls
//   ForwardAE_o/BE_o                    00 regfile, 01 W result, 10 M ALU result
//   StallCnt_o, FlushCnt_o              saturating performance counters
//   MemWait_o                           controller is waiting on data memory
module hazard_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D_i,
    input  logic [4:0]  Rs2D_i,
    input  logic [4:0]  Rs1E_i,
    input  logic [4:0]  Rs2E_i,
    input  logic [4:0]  RdE_i,
    input  logic [4:0]  RdM_i,
    input  logic [4:0]  RdW_i,
    input  logic [1:0]  ResultSrcE_i,
    input  logic        RegWriteM_i,
    input  logic        RegWriteW_i,
    input  logic        PCSrcE_i,
    input  logic        MemReqM_i,
    input  logic        MemReady_i,
    input  logic        CntClr_i,
    output logic        StallF_o,
    output logic        StallD_o,
    output logic        StallE_o,
    output logic        StallM_o,
    output logic        FlushD_o,
    output logic        FlushE_o,
    output logic        FlushW_o,
    output logic [1:0]  ForwardAE_o,
    output logic [1:0]  ForwardBE_o,
    output logic [15:0] StallCnt_o,
    output logic [15:0] FlushCnt_o,
    output logic        MemWait_o
);

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 16;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   mem_stall;
    logic   lw_stall;
    logic   any_stall;

    // Forward select for one E-stage source; M wins over W, x0 never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs);
        if (RegWriteM_i && (RdM_i != RW'(0)) && (RdM_i == rs))
            fwd_sel = 2'b10;
        else if (RegWriteW_i && (RdW_i != RW'(0)) && (RdW_i == rs))
            fwd_sel = 2'b01;
        else
            fwd_sel = 2'b00;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state plus the miss stall, which must be visible in the first miss cycle.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            RUN: begin
                if (MemReqM_i && !MemReady_i) begin
                    state_nxt = MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MemReady_i) state_nxt = RUN;
                else            mem_stall = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign lw_stall = (ResultSrcE_i == 2'b01) && (RdE_i != RW'(0)) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

    // Hazard priority: memory miss, then taken branch, then load-use.
    // Everything is held low while reset is asserted.
    always_comb begin
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (rst_n) begin
            ForwardAE_o = fwd_sel(Rs1E_i);
            ForwardBE_o = fwd_sel(Rs2E_i);
            if (mem_stall) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                FlushW_o = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (lw_stall) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    assign any_stall = StallF_o | StallD_o | StallE_o | StallM_o;
    assign MemWait_o = (state == MEM_WAIT);

    // Saturating counters; clear wins over increment. FlushD is only ever set by a branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt_o <= CW'(0);
            FlushCnt_o <= CW'(0);
        end else if (CntClr_i) begin
            StallCnt_o <= CW'(0);
            FlushCnt_o <= CW'(0);
        end else begin
            if (any_stall && (StallCnt_o != {CW{1'b1}}))
                StallCnt_o <= StallCnt_o + CW'(1);
            if (FlushD_o && (FlushCnt_o != {CW{1'b1}}))
                FlushCnt_o <= FlushCnt_o + CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for hazard_controller: the driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_controller;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       rwm, rww, pcsrc, memreq, memready, cntclr;
    } in_t;

    // Control bit order: StallF StallD StallE StallM FlushD FlushE FlushW
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1d = '0, rs2d = '0, rs1e = '0, rs2e = '0, rde = '0, rdm = '0, rdw = '0;
    logic [1:0]  rsrc = '0;
    logic        rwm = 1'b0, rww = 1'b0, pcsrc = 1'b0, memreq = 1'b0, memready = 1'b1, cntclr = 1'b0;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_wait;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic [43:0] exp_q[$];
    string       name_q[$];
    logic [15:0] m_scnt = '0;
    logic [15:0] m_fcnt = '0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .ResultSrcE_i(rsrc), .RegWriteM_i(rwm), .RegWriteW_i(rww),
        .PCSrcE_i(pcsrc), .MemReqM_i(memreq), .MemReady_i(memready), .CntClr_i(cntclr),
        .StallF_o(stall_f), .StallD_o(stall_d), .StallE_o(stall_e), .StallM_o(stall_m),
        .FlushD_o(flush_d), .FlushE_o(flush_e), .FlushW_o(flush_w),
        .ForwardAE_o(fwd_a), .ForwardBE_o(fwd_b),
        .StallCnt_o(stall_cnt), .FlushCnt_o(flush_cnt), .MemWait_o(mem_wait)
    );

    // Apply one cycle of stimulus and queue what the DUT must show this cycle.
    task automatic step(input in_t v, input logic [6:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic mw, input string nm);
        @(posedge clk);
        #1;
        rst_n = v.rst_n; rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e;
        rde = v.rde; rdm = v.rdm; rdw = v.rdw; rsrc = v.rsrc; rwm = v.rwm; rww = v.rww;
        pcsrc = v.pcsrc; memreq = v.memreq; memready = v.memready; cntclr = v.cntclr;
        if (!v.rst_n) begin
            m_scnt = '0;
            m_fcnt = '0;
        end
        exp_q.push_back({ctl, fa, fb, mw, m_scnt, m_fcnt});
        name_q.push_back(nm);
        // Counter values expected after the coming edge.
        if (v.rst_n) begin
            if (v.cntclr) begin
                m_scnt = '0;
                m_fcnt = '0;
            end else begin
                if ((|ctl[6:3]) && (m_scnt != 16'hFFFF)) m_scnt = m_scnt + 16'd1;
                if (ctl[2] && (m_fcnt != 16'hFFFF)) m_fcnt = m_fcnt + 16'd1;
            end
        end
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per negedge.
    always @(negedge clk) begin
        logic [43:0] act;
        logic [43:0] exp_v;
        string       nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                     fwd_a, fwd_b, mem_wait, stall_cnt, flush_cnt};
            total = total + 1;
            if (act !== exp_v) begin
                bad = bad + 1;
                $display("FAIL %s: got ctl=%b fa=%b fb=%b mw=%b sc=%h fc=%h, want ctl=%b fa=%b fb=%b mw=%b sc=%h fc=%h",
                         nm, act[43:37], act[36:35], act[34:33], act[32], act[31:16], act[15:0],
                         exp_v[43:37], exp_v[36:35], exp_v[34:33], exp_v[32], exp_v[31:16], exp_v[15:0]);
            end
        end
    end

    initial begin
        in_t idle, v;
        idle = '0;
        idle.rst_n = 1'b1;
        idle.memready = 1'b1;

        // Reset with every hazard input active: all outputs must stay low.
        v = idle; v.rst_n = 1'b0; v.rsrc = 2'b01; v.rde = 5'd5; v.rs1d = 5'd5;
        v.memreq = 1'b1; v.memready = 1'b0; v.pcsrc = 1'b1;
        v.rdm = 5'd7; v.rs1e = 5'd7; v.rwm = 1'b1;
        step(v, C_NONE, 2'b00, 2'b00, 1'b0, "reset0");
        step(v, C_NONE, 2'b00, 2'b00, 1'b0, "reset1");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "idle");

        // Load-use.
        v = idle; v.rsrc = 2'b01; v.rde = 5'd5; v.rs1d = 5'd5;
        step(v, C_LU, 2'b00, 2'b00, 1'b0, "lu_rs1");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "lu_release");
        v = idle; v.rsrc = 2'b01;
        step(v, C_NONE, 2'b00, 2'b00, 1'b0, "lu_x0");
        v = idle; v.rsrc = 2'b01; v.rde = 5'd9; v.rs2d = 5'd9;
        step(v, C_LU, 2'b00, 2'b00, 1'b0, "lu_rs2");
        v = idle; v.rsrc = 2'b00; v.rde = 5'd9; v.rs2d = 5'd9;
        step(v, C_NONE, 2'b00, 2'b00, 1'b0, "lu_not_load");

        // Forwarding priority.
        v = idle; v.rdm = 5'd7; v.rdw = 5'd7; v.rs1e = 5'd7; v.rs2e = 5'd7; v.rwm = 1'b1; v.rww = 1'b1;
        step(v, C_NONE, 2'b10, 2'b10, 1'b0, "fwd_m");
        v.rwm = 1'b0;
        step(v, C_NONE, 2'b01, 2'b01, 1'b0, "fwd_w");
        v = idle; v.rwm = 1'b1; v.rww = 1'b1;
        step(v, C_NONE, 2'b00, 2'b00, 1'b0, "fwd_x0");
        v = idle; v.rdm = 5'd3; v.rs2e = 5'd3; v.rwm = 1'b1; v.rdw = 5'd4; v.rs1e = 5'd4; v.rww = 1'b1;
        step(v, C_NONE, 2'b01, 2'b10, 1'b0, "fwd_mixed");

        // Branch, and branch beating load-use.
        v = idle; v.pcsrc = 1'b1;
        step(v, C_BR, 2'b00, 2'b00, 1'b0, "branch");
        v = idle; v.pcsrc = 1'b1; v.rsrc = 2'b01; v.rde = 5'd5; v.rs1d = 5'd5;
        step(v, C_BR, 2'b00, 2'b00, 1'b0, "br_vs_lu");

        // Miss: three not-ready cycles then ready; forwarding still active in MEM_WAIT.
        v.memreq = 1'b1; v.memready = 1'b0;
        step(v, C_MEM, 2'b00, 2'b00, 1'b0, "miss1_over_br_lu");
        v = idle; v.memreq = 1'b1; v.memready = 1'b0; v.rdm = 5'd7; v.rs1e = 5'd7; v.rwm = 1'b1;
        step(v, C_MEM, 2'b10, 2'b00, 1'b1, "miss2_fwd");
        step(v, C_MEM, 2'b10, 2'b00, 1'b1, "miss3");
        v = idle; v.memreq = 1'b1;
        step(v, C_NONE, 2'b00, 2'b00, 1'b1, "miss_ready");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "miss_done");

        // Clear while stalling; clear wins.
        v = idle; v.rsrc = 2'b01; v.rde = 5'd5; v.rs1d = 5'd5; v.cntclr = 1'b1;
        step(v, C_LU, 2'b00, 2'b00, 1'b0, "clr_with_stall");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "after_clr");

        // Async reset in MEM_WAIT, then fresh evaluation after release.
        v = idle; v.memreq = 1'b1; v.memready = 1'b0;
        step(v, C_MEM, 2'b00, 2'b00, 1'b0, "rmw_enter");
        step(v, C_MEM, 2'b00, 2'b00, 1'b1, "rmw_wait");
        v.rst_n = 1'b0;
        step(v, C_NONE, 2'b00, 2'b00, 1'b0, "rmw_async_reset");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "rmw_release");
        v = idle; v.memreq = 1'b1; v.memready = 1'b0;
        step(v, C_MEM, 2'b00, 2'b00, 1'b0, "rmw_fresh_miss");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b1, "rmw_ready");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "rmw_run");

        // Stall counter saturation, then clear.
        v = idle; v.rsrc = 2'b01; v.rde = 5'd5; v.rs1d = 5'd5;
        for (int i = 0; i < 65540; i++) step(v, C_LU, 2'b00, 2'b00, 1'b0, "sat_run");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "sat_hold");
        v.cntclr = 1'b1;
        step(v, C_LU, 2'b00, 2'b00, 1'b0, "sat_clr");
        step(idle, C_NONE, 2'b00, 2'b00, 1'b0, "sat_cleared");

        @(posedge clk);
        @(negedge clk);
        #1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
